mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Two-to-one line-memory arbiter below the split I-side and D-side memory ports that the pipeline control drives.
//  It consumes instruction-side and data-side line requests and grants one at a time to the single physical memory port.
//  It routes the memory response back to the granted requester only.
//  Granted requests are serviced to completion; no preemption.
// PARAMETERS
//  ADDR_W   32   byte address width
//  LINE_W   256  line width of read/write data
// PORTS
//  clk           in   1       clock; all state on rising edge
//  rst           in   1       asynchronous, active-high reset
//  inst_read     in   1       I-side line read request, level-held until inst_resp
//  inst_addr     in   ADDR_W  I-side line address
//  inst_rdata    out  LINE_W  I-side read data, valid only with inst_resp
//  inst_resp     out  1       I-side completion pulse, 1 cycle
//  data_read     in   1       D-side line read request, level-held until data_resp
//  data_write    in   1       D-side line write request, level-held until data_resp
//  data_addr     in   ADDR_W  D-side line address
//  data_wdata    in   LINE_W  D-side write data
//  data_rdata    out  LINE_W  D-side read data, valid only with data_resp
//  data_resp     out  1       D-side completion pulse, 1 cycle
//  pmem_read     out  1       physical memory read strobe
//  pmem_write    out  1       physical memory write strobe
//  pmem_addr     out  ADDR_W  physical memory address
//  pmem_wdata    out  LINE_W  physical memory write data
//  pmem_rdata    in   LINE_W  physical memory read data
//  pmem_resp     in   1       physical memory completion, 1 cycle
// BEHAVIOUR
//  - FSM states: IDLE, SERVE_I, SERVE_D, DONE. Reset state is IDLE.
//  - On reset: pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0, inst_resp=0, data_resp=0.
//  - Reset clears all registers and the last-grant flag. Asserting rst mid-transaction drops the strobes immediately (async).
//    After reset, an in-flight memory transaction is abandoned and its pmem_resp is ignored.
//  - IDLE: evaluate requests. A D-side request is data_read|data_write.
//    - Only I pending -> SERVE_I.
//    - Only D pending -> SERVE_D.
//    - Both pending -> SERVE_D (fixed priority; see CONFIGURATION).
//    - None pending -> stay in IDLE.
//  - On the grant edge, register address, operation and wdata from the winner.
//    pmem_* are driven from these registers, not from the live requester inputs.
//    The first strobe appears the cycle after the request is first seen in IDLE (1-cycle grant latency).
//  - D-side with data_read and data_write both high is illegal. The arbiter performs the write and never raises pmem_read.
//  - SERVE_x: hold the strobe and registered address/wdata steady until pmem_resp.
//    - In the pmem_resp cycle, drive x_resp=1 combinationally and pass pmem_rdata through to x_rdata.
//    - The other requester's resp stays 0.
//    - The strobe drops at the next edge; state goes to DONE.
//  - DONE: one idle bubble with no strobes, so the requester can drop its level request. Then go to IDLE.
//    - Minimum occupancy: 3 cycles + memory latency per transaction.
//  - Both rdata outputs are pmem_rdata (no muxing). Only the resp lines qualify them.
//  - A pmem_resp seen in IDLE or DONE is ignored; no resp is emitted.
//  - A requester that drops its request while being served does not abort the transaction; the resp is still issued.
//  - Requests arriving during SERVE_x or DONE wait. Starvation is bounded only under round-robin.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN
//   - Defined: a 1-bit last-grant flag, reset to I, updates on each grant.
//     On a simultaneous I+D request in IDLE, the side not granted last wins.
//   - Undefined: fixed D-over-I priority and no last-grant flag.
//     Rationale for the default: the D-side request belongs to the older instruction, and memory order follows program order.
// TESTING
//  - Reset: assert rst mid-SERVE_D with pmem_write=1 -> pmem_write=0 in the same cycle, state IDLE, no data_resp.
//  - Lone I read, addr 0x0000_1000, memory latency 4 -> pmem_read=1, pmem_addr=0x1000 from cycle+1.
//    inst_resp=1 for exactly 1 cycle carrying pmem_rdata; data_resp stays 0.
//  - Lone D write, addr 0x8000_0020, wdata pattern A5.. -> pmem_write=1 with registered addr/wdata.
//    Change data_addr mid-transaction -> pmem_addr unchanged; data_resp pulses once.
//  - I and D raised the same cycle, macro off -> D served first, then I.
//    Repeat 3 times -> D always first.
//  - I and D raised the same cycle, macro on, reset last-grant=I -> order D, I, D, I across back-to-back pairs.
//  - Spurious pmem_resp in IDLE -> no resp output and no state change.
//    data_read=data_write=1 -> write performed, pmem_read never 1.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the split I/D line ports,
// the arbiter and the single physical memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              inst_read;
  logic [ADDR_W-1:0] inst_addr;
  logic [LINE_W-1:0] inst_rdata;
  logic              inst_resp;
  logic              data_read;
  logic              data_write;
  logic [ADDR_W-1:0] data_addr;
  logic [LINE_W-1:0] data_wdata;
  logic [LINE_W-1:0] data_rdata;
  logic              data_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  inst_read, inst_addr,
    input  data_read, data_write,
    input  data_addr, data_wdata,
    input  pmem_rdata, pmem_resp,
    output inst_rdata, inst_resp,
    output data_rdata, data_resp,
    output pmem_read, pmem_write,
    output pmem_addr, pmem_wdata
  );

  modport master (
    output inst_read, inst_addr,
    output data_read, data_write,
    output data_addr, data_wdata,
    output pmem_rdata, pmem_resp,
    input  inst_rdata, inst_resp,
    input  data_rdata, data_resp,
    input  pmem_read, pmem_write,
    input  pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-to-one I/D line arbiter onto one memory port.
// ARB_ROUND_ROBIN_EN: round-robin tie-break (else D wins).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_req;
  logic              d_req;
  logic              pick_d;
  logic              grant;

  assign i_req = bus.inst_read;
  assign d_req = bus.data_read | bus.data_write;
  assign grant = (state == IDLE) && (i_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // I wins a tie only when D was granted last
  assign pick_d = d_req && (!i_req || !last_d);

  // remember which side took the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_d <= 1'b0;
    else if (grant) last_d <= pick_d;
  end
`else
  // D belongs to the older instruction, so it wins ties
  assign pick_d = d_req;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: grant, wait for memory, one bubble
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant)
          state_nx = pick_d ? SERVE_D : SERVE_I;
      end
      SERVE_I,
      SERVE_D: begin
        if (bus.pmem_resp) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // capture the winner's request on the grant edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      wr_q    <= pick_d & bus.data_write;
      addr_q  <= pick_d ? bus.data_addr : bus.inst_addr;
      wdata_q <= pick_d ? bus.data_wdata : '0;
    end
  end

  // strobes and responses follow state and registered op
  always_comb begin
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.inst_resp  = 1'b0;
    bus.data_resp  = 1'b0;
    unique case (1'b1)
      (state == SERVE_I): begin
        bus.pmem_read = 1'b1;
        bus.inst_resp = bus.pmem_resp;
      end
      (state == SERVE_D): begin
        bus.pmem_read  = ~wr_q;
        bus.pmem_write = wr_q;
        bus.data_resp  = bus.pmem_resp;
      end
      default: ;
    endcase
  end

  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.inst_rdata = bus.pmem_rdata;
  assign bus.data_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Bench acts as requesters and as physical memory.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input string tag,
                        input bit is_i,
                        input logic [31:0] exp_addr,
                        input bit exp_wr,
                        input logic [255:0] exp_wd,
                        input int lat,
                        input logic [255:0] rd);
    int n;
    n = 0;
    while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
      step();
      n++;
    end
    check({tag, "_strobe_seen"}, 256'(n < 20), 256'(1));
    if (n >= 20) return;
    check({tag, "_addr"}, 256'(bus.pmem_addr), 256'(exp_addr));
    check({tag, "_wr"}, 256'(bus.pmem_write), 256'(exp_wr));
    check({tag, "_rd"}, 256'(bus.pmem_read), 256'(!exp_wr));
    if (exp_wr)
      check({tag, "_wdata"}, bus.pmem_wdata, exp_wd);
    if (!is_i) bus.data_addr = ~bus.data_addr;
    repeat (lat - 1) step();
    check({tag, "_addr_held"}, 256'(bus.pmem_addr), 256'(exp_addr));
    check({tag, "_stb_held"},
          256'({bus.pmem_read, bus.pmem_write}),
          256'({!exp_wr, exp_wr}));
    bus.pmem_rdata = rd;
    bus.pmem_resp  = 1'b1;
    #1;
    check({tag, "_iresp"}, 256'(bus.inst_resp), 256'(is_i));
    check({tag, "_dresp"}, 256'(bus.data_resp), 256'(!is_i));
    if (is_i) check({tag, "_irdata"}, bus.inst_rdata, rd);
    else      check({tag, "_drdata"}, bus.data_rdata, rd);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    check({tag, "_done_stb"},
          256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check({tag, "_done_resp"},
          256'({bus.inst_resp, bus.data_resp}), 256'(0));
    if (is_i) begin
      bus.inst_read = 1'b0;
    end else begin
      bus.data_read  = 1'b0;
      bus.data_write = 1'b0;
    end
    step();
  endtask

  logic [255:0] pat_a5;
  logic [255:0] rd_i;
  logic [255:0] rd_d;

  initial begin
    checks = 0;
    errors = 0;
    pat_a5 = {32{8'hA5}};
    rd_i   = {8{32'h1234_5678}};
    rd_d   = {8{32'hCAFE_F00D}};
    rst             = 1'b1;
    bus.inst_read   = 1'b0;
    bus.inst_addr   = '0;
    bus.data_read   = 1'b0;
    bus.data_write  = 1'b0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;
    step();
    step();
    check("rst_rd", 256'(bus.pmem_read), 256'(0));
    check("rst_wr", 256'(bus.pmem_write), 256'(0));
    check("rst_addr", 256'(bus.pmem_addr), 256'(0));
    check("rst_wdata", bus.pmem_wdata, 256'(0));
    check("rst_resp",
          256'({bus.inst_resp, bus.data_resp}), 256'(0));
    rst = 1'b0;
    step();

    // lone I read, latency 4
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h0000_1000;
    step();
    check("i_lat1", 256'(bus.pmem_read), 256'(1));
    do_txn("lone_i", 1'b1, 32'h0000_1000, 1'b0, '0, 4, rd_i);

    // lone D write, address changed mid-flight
    bus.data_write = 1'b1;
    bus.data_addr  = 32'h8000_0020;
    bus.data_wdata = pat_a5;
    do_txn("lone_dw", 1'b0, 32'h8000_0020, 1'b1, pat_a5, 3, rd_d);

    // simultaneous requests, three times
    for (int k = 0; k < 3; k++) begin
      bus.inst_read = 1'b1;
      bus.inst_addr = 32'h0000_2000 + 32'(k * 64);
      bus.data_read = 1'b1;
      bus.data_addr = 32'h9000_0000 + 32'(k * 64);
      do_txn("pair_d", 1'b0, 32'h9000_0000 + 32'(k * 64),
             1'b0, '0, 2, rd_d);
      do_txn("pair_i", 1'b1, 32'h0000_2000 + 32'(k * 64),
             1'b0, '0, 2, rd_i);
    end

    // tie right after a lone D grant
    bus.data_read = 1'b1;
    bus.data_addr = 32'h9100_0000;
    do_txn("solo_d", 1'b0, 32'h9100_0000, 1'b0, '0, 1, rd_d);
    bus.inst_read = 1'b1;
    bus.inst_addr = 32'h0000_3000;
    bus.data_read = 1'b1;
    bus.data_addr = 32'h9200_0000;
`ifdef ARB_ROUND_ROBIN_EN
    do_txn("rr_i", 1'b1, 32'h0000_3000, 1'b0, '0, 2, rd_i);
    do_txn("rr_d", 1'b0, 32'h9200_0000, 1'b0, '0, 2, rd_d);
`else
    do_txn("fx_d", 1'b0, 32'h9200_0000, 1'b0, '0, 2, rd_d);
    do_txn("fx_i", 1'b1, 32'h0000_3000, 1'b0, '0, 2, rd_i);
`endif

    // spurious pmem_resp while idle
    bus.pmem_resp = 1'b1;
    #1;
    check("spur_resp",
          256'({bus.inst_resp, bus.data_resp}), 256'(0));
    step();
    bus.pmem_resp = 1'b0;
    #1;
    check("spur_stb",
          256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    step();

    // illegal read+write: write wins
    bus.data_read  = 1'b1;
    bus.data_write = 1'b1;
    bus.data_addr  = 32'h8000_0040;
    bus.data_wdata = ~pat_a5;
    do_txn("rw_both", 1'b0, 32'h8000_0040, 1'b1, ~pat_a5, 3, rd_d);

    // reset mid D write
    bus.data_write = 1'b1;
    bus.data_addr  = 32'h8000_0060;
    bus.data_wdata = pat_a5;
    step();
    check("mid_wr_on", 256'(bus.pmem_write), 256'(1));
    step();
    rst           = 1'b1;
    bus.pmem_resp = 1'b1;
    #1;
    check("mid_rst_wr", 256'(bus.pmem_write), 256'(0));
    check("mid_rst_dresp", 256'(bus.data_resp), 256'(0));
    check("mid_rst_addr", 256'(bus.pmem_addr), 256'(0));
    bus.data_write = 1'b0;
    step();
    rst = 1'b0;
    step();
    bus.pmem_resp = 1'b0;
    #1;
    check("post_rst_stb",
          256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check("post_rst_resp",
          256'({bus.inst_resp, bus.data_resp}), 256'(0));
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
